// File: rtl/regs_shift_deserializer.sv
// regs_shift_deserializer: packs a serial bit stream MSB-first into
// p_nbits-wide words and offers them downstream from a one-entry buffer.
// Ports: clk, reset (async, active-low), recv_msg/recv_val/recv_rdy
//   (serial input handshake), send_msg/send_val/send_rdy (word output
//   handshake), count (bits held in the current partial word).
// Optional: define REGS_SHIFT_DESERIALIZER_FLUSH_EN to add input flush,
//   which emits a partial word zero-extended on the left.
module regs_shift_deserializer #(
    parameter int unsigned p_nbits       = 8,
    parameter logic        p_reset_value = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       recv_msg,
    input  logic                       recv_val,
    output logic                       recv_rdy,
    output logic [p_nbits-1:0]         send_msg,
    output logic                       send_val,
    input  logic                       send_rdy,
    output logic [$clog2(p_nbits)-1:0] count
`ifdef REGS_SHIFT_DESERIALIZER_FLUSH_EN
    ,
    input  logic                       flush
`endif
);

    localparam int CW = $clog2(p_nbits);
    localparam logic [CW-1:0] LAST = CW'(p_nbits - 1);
    localparam logic [p_nbits-1:0] SR_INIT = {p_nbits{p_reset_value}};

    logic [p_nbits-1:0] sr;
    logic [p_nbits-1:0] sr_next;
    logic [p_nbits-1:0] obuf;
    logic [p_nbits-1:0] obuf_next;
    logic [p_nbits-1:0] word;
    logic [p_nbits-1:0] partial;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_next;
    logic               full;
    logic               full_next;
    logic               last;
    logic               recv_fire;
    logic               send_fire;
    logic               done;
    logic               flush_take;

    // Only the completing bit needs the buffer; earlier bits go into sr.
    always_comb begin
        last      = (cnt == LAST);
        recv_rdy  = ~last | ~full | send_rdy;
        recv_fire = recv_val & recv_rdy;
        send_fire = full & send_rdy;
        word      = {sr[p_nbits-2:0], recv_msg};
        done      = recv_fire & last;
    end

`ifdef REGS_SHIFT_DESERIALIZER_FLUSH_EN
    logic               slot_free;
    logic [p_nbits-1:0] mask;
    int unsigned        nbits;

    // sr keeps stale upper bits after a word completes, so the partial
    // word is masked down to the bits actually collected.
    always_comb begin
        slot_free  = ~full | send_rdy;
        flush_take = flush & slot_free & ((cnt != '0) | recv_fire);
        nbits      = 32'(cnt) + 32'(recv_fire);
        mask       = '0;
        for (int unsigned i = 0; i < p_nbits; i++) begin
            mask[i] = (i < nbits);
        end
        partial = (recv_fire ? word : sr) & mask;
    end
`else
    assign flush_take = 1'b0;
    assign partial    = '0;
`endif

    // A completing word overrides a same-cycle drain so throughput is
    // one word every p_nbits cycles.
    always_comb begin
        sr_next   = sr;
        cnt_next  = cnt;
        obuf_next = obuf;
        full_next = full;
        if (send_fire) begin
            full_next = 1'b0;
        end
        if (flush_take) begin
            obuf_next = partial;
            full_next = 1'b1;
            cnt_next  = '0;
            sr_next   = SR_INIT;
        end else if (done) begin
            obuf_next = word;
            full_next = 1'b1;
            cnt_next  = '0;
            sr_next   = word;
        end else if (recv_fire) begin
            sr_next  = word;
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr   <= SR_INIT;
            cnt  <= '0;
            obuf <= '0;
            full <= 1'b0;
        end else begin
            sr   <= sr_next;
            cnt  <= cnt_next;
            obuf <= obuf_next;
            full <= full_next;
        end
    end

    assign send_msg = obuf;
    assign send_val = full;
    assign count    = cnt;

endmodule
